// File: rtl/dbg_mem_loader_pkg.sv
// dbg_mem_loader_pkg: shared constants and helpers for the debug-port program loader.
//
// Contents:
//   St*      FSM state encodings (plain localparams so older tools can consume them)
//   nb_of()  byte-lane count for a given data width
//
// The VERIFY encoding is only reachable when DBG_MEM_LOADER_VERIFY_EN is defined.

package dbg_mem_loader_pkg;

    localparam int unsigned StateW = 3;

    localparam logic [StateW-1:0] StLoad   = 3'd0;
    localparam logic [StateW-1:0] StWrite  = 3'd1;
    localparam logic [StateW-1:0] StVerify = 3'd2;
    localparam logic [StateW-1:0] StSettle = 3'd3;
    localparam logic [StateW-1:0] StRun    = 3'd4;

    // Number of byte lanes in a data word; DATA_W is expected to be a multiple of 8.
    function automatic int unsigned nb_of(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dbg_mem_loader_if.sv
// dbg_mem_loader_if: bundles the loader's beat stream and the SoC debug memory port.
//
// Signals:
//   in_valid/in_ready   beat handshake (source -> loader)
//   in_data/in_mask     word and byte enables of the beat
//   in_last             final beat of the program
//   dbg_mem_op          debug port owns memory
//   dbg_adr/dbg_do      write address / write data
//   dbg_wren            byte write mask
//   dbg_di              read data from memory (used only by the verify pass)
//
// Modports:
//   master  the environment: stream source plus memory
//   slave   the loader itself

interface dbg_mem_loader_if
    import dbg_mem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();

    localparam int unsigned NB = nb_of(DATA_W);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [NB-1:0]     in_mask;
    logic              in_last;

    logic              dbg_mem_op;
    logic [ADDR_W-1:0] dbg_adr;
    logic [DATA_W-1:0] dbg_do;
    logic [NB-1:0]     dbg_wren;
    logic [DATA_W-1:0] dbg_di;

    modport master (
        output in_valid, in_data, in_mask, in_last, dbg_di,
        input  in_ready, dbg_mem_op, dbg_adr, dbg_do, dbg_wren
    );

    modport slave (
        input  in_valid, in_data, in_mask, in_last, dbg_di,
        output in_ready, dbg_mem_op, dbg_adr, dbg_do, dbg_wren
    );

endinterface

// File: rtl/dbg_mem_loader_cnt.sv
// dbg_mem_loader_cnt: loadable down-counter shared by the write-hold, verify and settle waits.
//
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset
//   load_i      load load_val_i (has priority over dec_i)
//   load_val_i  value to load
//   dec_i       decrement, saturating at zero
//   count_o     current count
//   zero_o      count is zero

module dbg_mem_loader_cnt #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic [Width-1:0] count_o,
    output logic             zero_o
);

    logic [Width-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/dbg_mem_loader.sv
// dbg_mem_loader: debug-port program loader. Holds the CPU in reset, writes a stream of
// masked words to consecutive addresses from BASE_ADR through the SoC debug memory port,
// waits HOLD_CYCLES and then releases cpu_n_reset.
//
// Ports:
//   clk          system clock
//   n_reset      asynchronous active-low reset
//   start        restart a load (honoured in RUN only)
//   bus          dbg_mem_loader_if.slave: beat stream in, debug memory port out
//   cpu_n_reset  CPU reset, active low
//   busy         high in every state except RUN
//   err          sticky verify mismatch
//
// Build option: define DBG_MEM_LOADER_VERIFY_EN to read back every written word and flag
// lane mismatches on err. Without it the VERIFY state is absent, dbg_di is ignored and err
// is tied low.
//
// Beat timing: accept (1 clock in LOAD), WR_CYCLES clocks with the port driven, one idle
// clock that closes WRITE, then (verify builds) 2 read-back clocks.

module dbg_mem_loader
    import dbg_mem_loader_pkg::*;
#(
    parameter int unsigned     ADDR_W      = 32,
    parameter int unsigned     DATA_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADR  = ADDR_W'(32'h20000),
    parameter int unsigned     WR_CYCLES   = 4,
    parameter int unsigned     HOLD_CYCLES = 8,
    parameter bit              BOOT_RUN    = 1'b0
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             start,
    dbg_mem_loader_if.slave  bus,
    output logic             cpu_n_reset,
    output logic             busy,
    output logic             err
);

    localparam int unsigned NB      = nb_of(DATA_W);
    localparam int unsigned CntMax  = (WR_CYCLES > HOLD_CYCLES) ? WR_CYCLES : HOLD_CYCLES;
    localparam int unsigned CntW    = $clog2(CntMax + 1);
    localparam logic [ADDR_W-1:0] AdrStep = ADDR_W'(NB);
    // WRITE counts WR_CYCLES..0: the port is driven while the count is non-zero, and the
    // clock at zero is the idle clock that closes the write.
    localparam logic [CntW-1:0] WrLoad   = CntW'(WR_CYCLES);
    localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYCLES - 1);
    localparam logic [StateW-1:0] StReset = BOOT_RUN ? StRun : StLoad;

    logic [StateW-1:0] state_d, state_q;
    logic [ADDR_W-1:0] adr_d, adr_q;
    logic              last_d, last_q;
    logic              mem_op_d, mem_op_q;
    logic [ADDR_W-1:0] dbg_adr_d, dbg_adr_q;
    logic [DATA_W-1:0] dbg_do_d, dbg_do_q;
    logic [NB-1:0]     wren_d, wren_q;
    logic              cpu_n_reset_d, cpu_n_reset_q;
    logic              busy_d, busy_q;
    logic              in_ready;

    logic              cnt_load;
    logic [CntW-1:0]   cnt_val;
    logic              cnt_dec;
    logic [CntW-1:0]   cnt_count;
    logic              cnt_zero;

    dbg_mem_loader_cnt #(
        .Width (CntW)
    ) u_cnt (
        .clk_i      (clk),
        .rst_ni     (n_reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .count_o    (cnt_count),
        .zero_o     (cnt_zero)
    );

    // Gated by n_reset so the source sees no ready while the block is held in reset.
    assign in_ready = (state_q == StLoad) && n_reset;

`ifdef DBG_MEM_LOADER_VERIFY_EN
    logic [NB-1:0] mask_d, mask_q;
    logic          err_d, err_q;
    logic          lane_mismatch;

    // dbg_do_q still holds the written word during VERIFY.
    always_comb begin
        lane_mismatch = 1'b0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (mask_q[i] && (bus.dbg_di[8*i +: 8] != dbg_do_q[8*i +: 8])) begin
                lane_mismatch = 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    logic unused_dbg_di;
    assign unused_dbg_di = ^bus.dbg_di;
    assign err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        last_d    = last_q;
        mem_op_d  = mem_op_q;
        dbg_adr_d = dbg_adr_q;
        dbg_do_d  = dbg_do_q;
        wren_d    = wren_q;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        cnt_dec   = 1'b0;
`ifdef DBG_MEM_LOADER_VERIFY_EN
        mask_d    = mask_q;
        err_d     = err_q;
`endif

        case (state_q)
            StLoad: begin
                if (bus.in_valid && in_ready) begin
                    last_d = bus.in_last;
`ifdef DBG_MEM_LOADER_VERIFY_EN
                    mask_d = bus.in_mask;
`endif
                    if (bus.in_mask == '0) begin
                        // Empty beat: consume it and skip its address without a port cycle.
                        adr_d = adr_q + AdrStep;
                        if (bus.in_last) begin
                            state_d  = StSettle;
                            cnt_load = 1'b1;
                            cnt_val  = HoldLoad;
                        end
                    end else begin
                        state_d   = StWrite;
                        mem_op_d  = 1'b1;
                        dbg_adr_d = adr_q;
                        dbg_do_d  = bus.in_data;
                        wren_d    = bus.in_mask;
                        cnt_load  = 1'b1;
                        cnt_val   = WrLoad;
                    end
                end
            end

            StWrite: begin
                if (cnt_zero) begin
                    adr_d = adr_q + AdrStep;
`ifdef DBG_MEM_LOADER_VERIFY_EN
                    state_d  = StVerify;
                    mem_op_d = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = CntW'(1);
`else
                    if (last_q) begin
                        state_d  = StSettle;
                        cnt_load = 1'b1;
                        cnt_val  = HoldLoad;
                    end else begin
                        state_d = StLoad;
                    end
`endif
                end else begin
                    cnt_dec = 1'b1;
                    if (cnt_count == CntW'(1)) begin
                        mem_op_d = 1'b0;
                        wren_d   = '0;
                    end
                end
            end

`ifdef DBG_MEM_LOADER_VERIFY_EN
            StVerify: begin
                // Two read clocks on the same address; dbg_di is sampled on the second.
                if (cnt_zero) begin
                    mem_op_d = 1'b0;
                    if (lane_mismatch) begin
                        err_d = 1'b1;
                    end
                    if (last_q) begin
                        state_d  = StSettle;
                        cnt_load = 1'b1;
                        cnt_val  = HoldLoad;
                    end else begin
                        state_d = StLoad;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
`endif

            StSettle: begin
                if (cnt_zero) begin
                    state_d = StRun;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            StRun: begin
                if (start) begin
                    state_d = StLoad;
                    adr_d   = BASE_ADR;
`ifdef DBG_MEM_LOADER_VERIFY_EN
                    err_d   = 1'b0;
`endif
                end
            end

            default: begin
                state_d  = StLoad;
                mem_op_d = 1'b0;
                wren_d   = '0;
            end
        endcase

        // Registered from the next state so cpu_n_reset cannot glitch on a state decode.
        cpu_n_reset_d = (state_d == StRun);
        busy_d        = (state_d != StRun);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= StReset;
            adr_q         <= BASE_ADR;
            last_q        <= 1'b0;
            mem_op_q      <= 1'b0;
            dbg_adr_q     <= BASE_ADR;
            dbg_do_q      <= '0;
            wren_q        <= '0;
            cpu_n_reset_q <= BOOT_RUN;
            busy_q        <= !BOOT_RUN;
        end else begin
            state_q       <= state_d;
            adr_q         <= adr_d;
            last_q        <= last_d;
            mem_op_q      <= mem_op_d;
            dbg_adr_q     <= dbg_adr_d;
            dbg_do_q      <= dbg_do_d;
            wren_q        <= wren_d;
            cpu_n_reset_q <= cpu_n_reset_d;
            busy_q        <= busy_d;
        end
    end

`ifdef DBG_MEM_LOADER_VERIFY_EN
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            mask_q <= '0;
            err_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            err_q  <= err_d;
        end
    end
`endif

    assign bus.in_ready   = in_ready;
    assign bus.dbg_mem_op = mem_op_q;
    assign bus.dbg_adr    = dbg_adr_q;
    assign bus.dbg_do     = dbg_do_q;
    assign bus.dbg_wren   = wren_q;
    assign cpu_n_reset    = cpu_n_reset_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_dbg_mem_loader.sv
// tb_dbg_mem_loader: self-checking bench for dbg_mem_loader with default parameters.
// Expected writes are pushed to a scoreboard when a beat is offered and popped by a port
// monitor when the write on dbg_* finishes. A small byte-lane memory model sits on the port.
// Define DBG_MEM_LOADER_VERIFY_EN for both RTL and bench to exercise the read-back pass.

module tb_dbg_mem_loader;

    localparam int unsigned WR   = 4;
    localparam int unsigned HOLD = 8;
    localparam logic [31:0] BASE = 32'h20000;
`ifdef DBG_MEM_LOADER_VERIFY_EN
    localparam int unsigned VX = 2;
`else
    localparam int unsigned VX = 0;
`endif
    localparam int unsigned BEAT = WR + 2 + VX;
    // Last write's port cycles end, one idle clock closes WRITE, verify clocks, then settle.
    localparam int unsigned SETTLE_GAP = 1 + VX + HOLD;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] data;
        logic [3:0]  wren;
    } wr_t;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    logic start = 1'b0;
    logic cpu_n_reset, busy, err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    wr_t sb[$];
    int  starts_q[$];
    logic [31:0] exp_adr = BASE;
    int  end_cyc = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] di_r = '0;
    bit          corrupt = 1'b0;

    dbg_mem_loader_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dbg_mem_loader #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .BASE_ADR    (BASE),
        .WR_CYCLES   (WR),
        .HOLD_CYCLES (HOLD),
        .BOOT_RUN    (1'b0)
    ) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .start       (start),
        .bus         (bus),
        .cpu_n_reset (cpu_n_reset),
        .busy        (busy),
        .err         (err)
    );

    assign bus.dbg_di = di_r;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d errors=%0d)", checks, errors);
        $fatal(1);
    end

    // Memory model: byte-lane writes, read data refreshed for the loader's read-back.
    always @(negedge clk) begin
        logic [31:0] w;
        if (n_reset && bus.dbg_mem_op && (bus.dbg_wren != 4'h0)) begin
            w = mem.exists(bus.dbg_adr) ? mem[bus.dbg_adr] : 32'h0;
            for (int i = 0; i < 4; i++) begin
                if (bus.dbg_wren[i]) w[8*i +: 8] = bus.dbg_do[8*i +: 8];
            end
            mem[bus.dbg_adr] = w;
        end
        w = mem.exists(bus.dbg_adr) ? mem[bus.dbg_adr] : 32'h0;
        if (corrupt && bus.dbg_adr == BASE + 32'h4) w[7:0] = ~w[7:0];
        di_r = w;
    end

    // Port monitor: a write is a run of clocks with dbg_wren != 0; compare when it ends.
    int          run_len = 0;
    bit          run_bad = 1'b0;
    logic [31:0] run_adr, run_data;
    logic [3:0]  run_wren;
    always @(negedge clk) begin
        wr_t e;
        if (!n_reset) begin
            run_len = 0;
        end else if (bus.dbg_wren != 4'h0) begin
            if (run_len == 0) begin
                run_adr  = bus.dbg_adr;
                run_data = bus.dbg_do;
                run_wren = bus.dbg_wren;
                run_bad  = (bus.dbg_mem_op !== 1'b1);
                starts_q.push_back(cyc);
            end else if (bus.dbg_adr !== run_adr || bus.dbg_do !== run_data ||
                         bus.dbg_wren !== run_wren || bus.dbg_mem_op !== 1'b1) begin
                run_bad = 1'b1;
            end
            run_len++;
        end else if (run_len != 0) begin
            end_cyc = cyc;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: adr=%h data=%h wren=%h, no write expected",
                         run_adr, run_data, run_wren);
            end else begin
                e = sb.pop_front();
                if (run_adr !== e.adr || run_data !== e.data || run_wren !== e.wren) begin
                    errors++;
                    $display("FAIL write_content: got adr=%h data=%h wren=%h, want %h %h %h",
                             run_adr, run_data, run_wren, e.adr, e.data, e.wren);
                end
                checks++;
                if (run_len != WR || run_bad) begin
                    errors++;
                    $display("FAIL write_hold: held %0d clocks (unstable=%0d), want %0d stable",
                             run_len, run_bad, WR);
                end
            end
            run_len = 0;
        end
    end

    // Offer one beat (called at a negedge); returns at the negedge after it is accepted.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] m, input logic l,
                             input bit expect_write);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_mask  = m;
        bus.in_last  = l;
        while (bus.in_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 200) begin
            errors++;
            $display("FAIL beat_accept: in_ready=%b after %0d clocks, want 1", bus.in_ready, guard);
        end
        if (expect_write) sb.push_back('{adr: exp_adr, data: d, wren: m});
        exp_adr += 32'h4;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_sb_empty();
        int guard = 0;
        while ((sb.size() != 0 || bus.in_ready !== 1'b1) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 100) begin
            errors++;
            $display("FAIL write_drain: %0d writes outstanding, want 0", sb.size());
        end
    endtask

    task automatic wait_run(output int at_cyc);
        int guard = 0;
        while (cpu_n_reset !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        at_cyc = cyc;
        checks++;
        if (guard >= 200) begin
            errors++;
            $display("FAIL reach_run: cpu_n_reset=%b after %0d clocks, want 1", cpu_n_reset, guard);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.dbg_mem_op !== 1'b0 || bus.dbg_wren !== 4'h0 || bus.dbg_do !== 32'h0 ||
            bus.dbg_adr !== BASE) begin
            errors++;
            $display("FAIL reset_port: op=%b wren=%h do=%h adr=%h, want 0 0 0 %h",
                     bus.dbg_mem_op, bus.dbg_wren, bus.dbg_do, bus.dbg_adr, BASE);
        end
        checks++;
        if (cpu_n_reset !== 1'b0 || busy !== 1'b1 || err !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: cpu_n_reset=%b busy=%b err=%b in_ready=%b, want 0 1 0 0",
                     cpu_n_reset, busy, err, bus.in_ready);
        end
        n_reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_ready: in_ready=%b, want 1", bus.in_ready);
        end
    endtask

    task automatic test_zero_mask();
        mem[BASE] = 32'h0;
        send_beat(32'hCAFEF00D, 4'h0, 1'b0, 1'b0);
        checks++;
        if (bus.dbg_mem_op !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_mask_skip: op=%b in_ready=%b, want 0 1", bus.dbg_mem_op, bus.in_ready);
        end
        send_beat(32'h12345678, 4'hF, 1'b0, 1'b1);
        wait_sb_empty();
        checks++;
        if (mem[BASE] !== 32'h0 || mem[BASE + 32'h4] !== 32'h12345678) begin
            errors++;
            $display("FAIL zero_mask_mem: [BASE]=%h [BASE+4]=%h, want 0 12345678",
                     mem[BASE], mem[BASE + 32'h4]);
        end
    endtask

    task automatic test_async_reset();
        send_beat(32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        n_reset = 1'b0;
        #1;
        checks++;
        if (bus.dbg_mem_op !== 1'b0 || bus.dbg_wren !== 4'h0 || bus.dbg_adr !== BASE ||
            cpu_n_reset !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: op=%b wren=%h adr=%h cpu_n_reset=%b busy=%b, want 0 0 %h 0 1",
                     bus.dbg_mem_op, bus.dbg_wren, bus.dbg_adr, cpu_n_reset, busy, BASE);
        end
        @(negedge clk);
        @(negedge clk);
        n_reset = 1'b1;
        exp_adr = BASE;
        @(negedge clk);
    endtask

    task automatic test_masked_beat();
        mem[BASE] = 32'h11223344;
        send_beat(32'hAABBCCDD, 4'b0010, 1'b0, 1'b1);
        wait_sb_empty();
        checks++;
        if (mem[BASE] !== 32'h1122CC44) begin
            errors++;
            $display("FAIL masked_mem: got %h, want 1122cc44", mem[BASE]);
        end
    endtask

    task automatic test_back_pressure();
        int bad = 0;
        int guard = 0;
        send_beat(32'h0BADF00D, 4'hF, 1'b1, 1'b1);
        // Keep offering a beat through WRITE/SETTLE into RUN; none may be taken.
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h55555555;
        bus.in_mask  = 4'hF;
        bus.in_last  = 1'b0;
        while (cpu_n_reset !== 1'b1 && guard < 200) begin
            if (bus.in_ready !== 1'b0) bad++;
            @(negedge clk);
            guard++;
        end
        repeat (3) begin
            if (bus.in_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bad != 0 || guard >= 200) begin
            errors++;
            $display("FAIL backpressure: %0d clocks with in_ready high, waited %0d, want 0", bad, guard);
        end
        checks++;
        if (sb.size() != 0 || mem[BASE + 32'h4] !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL backpressure_mem: pending=%0d [BASE+4]=%h, want 0 0badf00d",
                     sb.size(), mem[BASE + 32'h4]);
        end
    endtask

    task automatic test_restart();
        checks++;
        if (cpu_n_reset !== 1'b1 || busy !== 1'b0 || bus.in_ready !== 1'b0 ||
            bus.dbg_mem_op !== 1'b0 || bus.dbg_wren !== 4'h0 || err !== 1'b0) begin
            errors++;
            $display("FAIL run_state: cpu_n_reset=%b busy=%b rdy=%b op=%b wren=%h err=%b, want 1 0 0 0 0 0",
                     cpu_n_reset, busy, bus.in_ready, bus.dbg_mem_op, bus.dbg_wren, err);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_adr = BASE;
        checks++;
        if (cpu_n_reset !== 1'b0 || busy !== 1'b1 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL restart: cpu_n_reset=%b busy=%b in_ready=%b, want 0 1 1",
                     cpu_n_reset, busy, bus.in_ready);
        end
    endtask

    task automatic test_program_load();
        logic [31:0] prog [8];
        int run_at;
        prog = '{32'h00000137, 32'h03200793, 32'h00f10623, 32'h03100793,
                 32'h00f106a3, 32'h00d14503, 32'h00c14503, 32'h0000006f};
        starts_q.delete();
        for (int i = 0; i < 8; i++) send_beat(prog[i], 4'hF, (i == 7), 1'b1);
        wait_run(run_at);
        checks++;
        if (run_at - end_cyc != int'(SETTLE_GAP)) begin
            errors++;
            $display("FAIL settle_delay: cpu_n_reset rose %0d clocks after last write, want %0d",
                     run_at - end_cyc, SETTLE_GAP);
        end
        checks++;
        if (starts_q.size() != 8) begin
            errors++;
            $display("FAIL write_count: saw %0d writes, want 8", starts_q.size());
        end else begin
            for (int i = 1; i < 8; i++) begin
                checks++;
                if (starts_q[i] - starts_q[i-1] != int'(BEAT)) begin
                    errors++;
                    $display("FAIL beat_period: beat %0d after %0d clocks, want %0d",
                             i, starts_q[i] - starts_q[i-1], BEAT);
                end
            end
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem[BASE + 32'(4 * i)] !== prog[i]) begin
                errors++;
                $display("FAIL prog_mem: [%h]=%h, want %h", BASE + 32'(4 * i),
                         mem[BASE + 32'(4 * i)], prog[i]);
            end
        end
    endtask

`ifdef DBG_MEM_LOADER_VERIFY_EN
    task automatic test_verify();
        int run_at;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_adr = BASE;
        corrupt = 1'b1;
        send_beat(32'h01020304, 4'hF, 1'b0, 1'b1);
        wait_sb_empty();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL verify_clean: err=%b after good beat, want 0", err);
        end
        send_beat(32'h05060708, 4'hF, 1'b1, 1'b1);
        wait_run(run_at);
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL verify_err: err=%b busy=%b in RUN, want 1 0", err, busy);
        end
        corrupt = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL verify_clear: err=%b after start, want 0", err);
        end
    endtask
`endif

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_mask  = '0;
        bus.in_last  = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_zero_mask();
        test_async_reset();
        test_masked_beat();
        test_back_pressure();
        test_restart();
        test_program_load();
`ifdef DBG_MEM_LOADER_VERIFY_EN
        test_verify();
`endif
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: %0d writes never seen, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
